// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame length and command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for PS2_CLK/PS2_DAT with a registered
// falling-edge pulse on the clock line.
module ps2_line_sync (
    input  logic clock,
    input  logic resetn,
    input  logic clk_i,
    input  logic dat_i,
    output logic clk_o,
    output logic dat_o,
    output logic fe_o
);

    logic clk_meta_q;
    logic clk_sync_q;
    logic clk_prev_q;
    logic dat_meta_q;
    logic dat_sync_q;
    logic fe_q;

    // Idle bus is high, so the flops reset to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            fe_q       <= 1'b0;
        end else begin
            clk_meta_q <= clk_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= dat_i;
            dat_sync_q <= dat_meta_q;
            fe_q       <= clk_prev_q & ~clk_sync_q;
        end
    end

    assign clk_o = clk_sync_q;
    assign dat_o = dat_sync_q;
    assign fe_o  = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, shift, ACK).
// Define PS2_TX_TIMEOUT_EN to add the stalled-device timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       error
);

    localparam longint INH_L = longint'(INHIBIT_US) * longint'(CLK_FREQ_HZ) / 64'sd1_000_000;
    localparam longint TO_L  = longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ) / 64'sd1_000_000;
    localparam int INH_CYC = int'(INH_L);
    localparam int TO_CYC  = int'(TO_L);
    localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
    localparam logic [3:0]       STOP_IDX = 4'(FRAME_LEN - 2);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);
`endif

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       byte_q, byte_d;
    logic             dat_oe_q, dat_oe_d;
    logic             clk_s, dat_s, fe;
    logic             tx_bit;

    ps2_line_sync u_sync (
        .clock  (clock),
        .resetn (resetn),
        .clk_i  (ps2_clk_in),
        .dat_i  (ps2_dat_in),
        .clk_o  (clk_s),
        .dat_o  (dat_s),
        .fe_o   (fe)
    );

    always_comb begin
        tx_bit = 1'b1;
        if (bit_q < 4'd8) begin
            tx_bit = byte_q[bit_q[2:0]];
        end else if (bit_q == 4'd8) begin
            tx_bit = odd_parity(byte_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        dat_oe_d = dat_oe_q;
        unique case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (cmd_valid) begin
                    byte_d  = cmd_data;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    bit_d    = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (fe) begin
                    dat_oe_d = ~tx_bit;
                    bit_d    = bit_q + 4'd1;
                    if (bit_q == STOP_IDX) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (fe) begin
                    state_d = dat_s ? ERR : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // The inhibit counter is reused as the device-response timeout.
        if (state_q inside {SHIFT, ACK, WAIT_IDLE}) begin
            if (cnt_q == TO_LAST) begin
                dat_oe_d = 1'b0;
                state_d  = ERR;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign ps2_clk_oe = (state_q == INHIBIT);
    assign ps2_dat_oe = dat_oe_q;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);

endmodule
